// File: rtl/wide_add_sequencer.sv
// Byte-serial wide add/subtract controller driving one shared external 8-bit adder,
// least-significant byte first, with valid/ready handshakes on operands and result.
module wide_add_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [8*WORDS-1:0]   i_in_a,
   input  logic [8*WORDS-1:0]   i_in_b,
   input  logic                 i_in_cin,
   input  logic                 i_in_sub,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [8*WORDS-1:0]   o_out_sum,
   output logic                 o_out_cout,
   output logic                 o_busy,
   output logic [7:0]           o_add_a,
   output logic [7:0]           o_add_b,
   output logic                 o_add_cin,
   input  logic [7:0]           i_add_sum,
   input  logic                 i_add_cout
);

   localparam int W     = 8 * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Selects byte idx of a wide vector without a variable part-select.
   function automatic logic [7:0] f_byte_sel(input logic [W-1:0] v, input logic [IDX_W-1:0] idx);
      logic [7:0] b;
      b = 8'h00;
      for (int k = 0; k < WORDS; k++) begin
         b = b | (v[8*k +: 8] & {8{idx == IDX_W'(k)}});
      end
      return b;
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [W-1:0]       r_a;
   logic [W-1:0]       w_a_nxt;
   logic [W-1:0]       r_b;
   logic [W-1:0]       w_b_nxt;
   logic [W-1:0]       r_sum;
   logic [W-1:0]       w_sum_nxt;
   logic               r_carry;
   logic               w_carry_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_idx_nxt;

   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;
   logic [W-1:0]       r_out_sum;
   logic               r_out_cout;
   logic [7:0]         r_add_a;
   logic [7:0]         r_add_b;
   logic               r_add_cin;

   logic               w_in_ready_nxt;
   logic               w_out_valid_nxt;
   logic               w_busy_nxt;
   logic [W-1:0]       w_out_sum_nxt;
   logic               w_out_cout_nxt;
   logic [7:0]         w_add_a_nxt;
   logic [7:0]         w_add_b_nxt;
   logic               w_add_cin_nxt;

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_sum_nxt   = r_sum;
      w_carry_nxt = r_carry;
      w_idx_nxt   = r_idx;
      case (r_state)
         S_IDLE: begin
            if (i_in_valid && r_in_ready) begin
               w_a_nxt     = i_in_a;
               w_b_nxt     = i_in_sub ? ~i_in_b : i_in_b;
               w_carry_nxt = i_in_sub ? 1'b1 : i_in_cin;
               w_idx_nxt   = {IDX_W{1'b0}};
               w_sum_nxt   = {W{1'b0}};
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            // Only the byte currently on the adder is written back.
            for (int k = 0; k < WORDS; k++) begin
               w_sum_nxt[8*k +: 8] = (r_idx == IDX_W'(k)) ? i_add_sum : r_sum[8*k +: 8];
            end
            w_carry_nxt = i_add_cout;
            if (r_idx == IDX_W'(WORDS - 1)) begin
               w_state_nxt = S_DONE;
            end else begin
               w_idx_nxt   = r_idx + IDX_W'(1);
               w_state_nxt = S_RUN;
            end
         end
         S_DONE: begin
            if (i_out_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, derived from the next state so they can be registered.
   always_comb begin
      w_in_ready_nxt  = (w_state_nxt == S_IDLE);
      w_out_valid_nxt = (w_state_nxt == S_DONE);
      w_busy_nxt      = (w_state_nxt == S_RUN) || (w_state_nxt == S_DONE);
      w_out_sum_nxt   = {W{1'b0}};
      w_out_cout_nxt  = 1'b0;
      w_add_a_nxt     = 8'h00;
      w_add_b_nxt     = 8'h00;
      w_add_cin_nxt   = 1'b0;
      if (w_state_nxt == S_DONE) begin
         w_out_sum_nxt  = w_sum_nxt;
         w_out_cout_nxt = w_carry_nxt;
      end else if (w_state_nxt == S_RUN) begin
         w_add_a_nxt   = f_byte_sel(w_a_nxt, w_idx_nxt);
         w_add_b_nxt   = f_byte_sel(w_b_nxt, w_idx_nxt);
         w_add_cin_nxt = w_carry_nxt;
      end else begin
         w_out_sum_nxt = {W{1'b0}};
      end
   end

   // Datapath registers; reset discards any partial result.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a     <= {W{1'b0}};
         r_b     <= {W{1'b0}};
         r_sum   <= {W{1'b0}};
         r_carry <= 1'b0;
         r_idx   <= {IDX_W{1'b0}};
      end else begin
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_sum   <= w_sum_nxt;
         r_carry <= w_carry_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_out_sum   <= {W{1'b0}};
         r_out_cout  <= 1'b0;
         r_add_a     <= 8'h00;
         r_add_b     <= 8'h00;
         r_add_cin   <= 1'b0;
      end else begin
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_busy      <= w_busy_nxt;
         r_out_sum   <= w_out_sum_nxt;
         r_out_cout  <= w_out_cout_nxt;
         r_add_a     <= w_add_a_nxt;
         r_add_b     <= w_add_b_nxt;
         r_add_cin   <= w_add_cin_nxt;
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_busy      = r_busy;
   assign o_out_sum   = r_out_sum;
   assign o_out_cout  = r_out_cout;
   assign o_add_a     = r_add_a;
   assign o_add_b     = r_add_b;
   assign o_add_cin   = r_add_cin;

endmodule
